// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the multi-approach traffic light controller.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } tl_state_e;

  // Duration register selectors on cfg_addr
  localparam logic [1:0] CFG_GREEN  = 2'd0;
  localparam logic [1:0] CFG_YELLOW = 2'd1;
  localparam logic [1:0] CFG_ALLRED = 2'd2;
  localparam logic [1:0] CFG_PED    = 2'd3;

endpackage

// File: rtl/tl_tick_prescaler.sv
// Divides the system clock down to the phase tick; freezes while disabled.
module tl_tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_cnt;

  assign o_tick = i_enable && (r_cnt == LAST);

  // Count 0..PRESCALE-1 while enabled, wrapping on the tick cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= o_tick ? '0 : r_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_mc_ctrl.sv
// Round-robin N-approach traffic light sequencer with programmable phase
// durations, latched pedestrian requests with green extension, and flash mode.
module traffic_light_mc_ctrl
  import traffic_light_pkg::*;
#(
  parameter int N_DIR     = 2,
  parameter int CNT_W     = 16,
  parameter int PRESCALE  = 1000,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int PED_EXT_T = 5,
  localparam int DIR_W    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic [N_DIR-1:0] ped_req,
  input  logic             flash_mode,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [N_DIR-1:0] ped_walk,
  output logic [DIR_W-1:0] cur_dir
);

  // Timer load value for a duration D: max(D,1)-1, saturating at the timer range
  function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W:0] d);
    logic [CNT_W:0] m1;
    m1 = (d == '0) ? '0 : d - {{CNT_W{1'b0}}, 1'b1};
    return m1[CNT_W] ? {CNT_W{1'b1}} : m1[CNT_W-1:0];
  endfunction

  function automatic logic [N_DIR-1:0] f_onehot(input logic [DIR_W-1:0] dir);
    logic [N_DIR-1:0] oh;
    for (int i = 0; i < N_DIR; i++) oh[i] = (dir == DIR_W'(i));
    return oh;
  endfunction

  tl_state_e        r_state;
  logic [DIR_W-1:0] r_cur_dir;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_dur [4];
  logic [N_DIR-1:0] r_latch;
  logic [N_DIR-1:0] r_red, r_yellow, r_green, r_walk;

  logic             w_tick;
  logic [N_DIR-1:0] w_dir_oh;
  logic             w_ped_hit;
  logic             w_green_entry;
  logic [N_DIR-1:0] w_ped_clr;
  logic [CNT_W:0]   w_green_dur;
  logic [DIR_W-1:0] w_next_dir;

  tl_tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  assign w_dir_oh      = f_onehot(r_cur_dir);
  assign w_ped_hit     = (r_latch & w_dir_oh) != '0;
  assign w_green_entry = !flash_mode && (r_state == ST_ALLRED) && w_tick && (r_timer == '0);
  assign w_ped_clr     = w_green_entry ? w_dir_oh : '0;
  assign w_green_dur   = {1'b0, r_dur[CFG_GREEN]} + (w_ped_hit ? {1'b0, r_dur[CFG_PED]} : '0);
  assign w_next_dir    = (r_cur_dir == DIR_W'(N_DIR - 1)) ? '0 : r_cur_dir + DIR_W'(1);

  assign red      = r_red;
  assign yellow   = r_yellow;
  assign green    = r_green;
  assign ped_walk = r_walk;
  assign cur_dir  = r_cur_dir;

  // Duration registers: writable at any time, read only at phase entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dur[CFG_GREEN]  <= CNT_W'(GREEN_T);
      r_dur[CFG_YELLOW] <= CNT_W'(YELLOW_T);
      r_dur[CFG_ALLRED] <= CNT_W'(ALLRED_T);
      r_dur[CFG_PED]    <= CNT_W'(PED_EXT_T);
    end else if (cfg_we) begin
      r_dur[cfg_addr] <= cfg_wdata;
    end
  end

  // Sticky pedestrian latches; a new request beats the clear at green entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_latch <= '0;
    end else begin
      r_latch <= (r_latch & ~w_ped_clr) | ped_req;
    end
  end

  // Phase sequencer with registered lamp outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ALLRED;
      r_cur_dir <= '0;
      r_timer   <= f_load((CNT_W+1)'(ALLRED_T));
      r_red     <= '1;
      r_yellow  <= '0;
      r_green   <= '0;
      r_walk    <= '0;
    end else if (flash_mode) begin
      if (r_state != ST_FLASH) begin
        r_state  <= ST_FLASH;
        r_red    <= '0;
        r_green  <= '0;
        r_walk   <= '0;
        r_yellow <= '1;
      end else if (w_tick) begin
        r_yellow <= ~r_yellow;
      end
    end else if (r_state == ST_FLASH) begin
      r_state   <= ST_ALLRED;
      r_cur_dir <= '0;
      r_timer   <= f_load({1'b0, r_dur[CFG_ALLRED]});
      r_red     <= '1;
      r_yellow  <= '0;
    end else if (w_tick) begin
      if (r_timer != '0) begin
        r_timer <= r_timer - CNT_W'(1);
      end else begin
        case (r_state)
          ST_ALLRED: begin
            r_state <= ST_GREEN;
            r_timer <= f_load(w_green_dur);
            r_green <= w_dir_oh;
            r_red   <= ~w_dir_oh;
            r_walk  <= w_ped_hit ? w_dir_oh : '0;
          end
          ST_GREEN: begin
            r_state  <= ST_YELLOW;
            r_timer  <= f_load({1'b0, r_dur[CFG_YELLOW]});
            r_green  <= '0;
            r_walk   <= '0;
            r_yellow <= w_dir_oh;
          end
          ST_YELLOW: begin
            r_state   <= ST_ALLRED;
            r_cur_dir <= w_next_dir;
            r_timer   <= f_load({1'b0, r_dur[CFG_ALLRED]});
            r_yellow  <= '0;
            r_red     <= '1;
          end
          default: begin
            r_state <= ST_ALLRED;
            r_red   <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_mc_ctrl.sv
// Scoreboard bench: a phase-list reference model predicts the lamp frame after
// every clock; a monitor compares each DUT frame against the queued prediction.
module tb_traffic_light_mc_ctrl;

  localparam int N  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic [N-1:0]  ped_req = '0;
  logic          flash_mode = 1'b0;
  logic [N-1:0]  red, yellow, green, ped_walk;
  logic          cur_dir;

  traffic_light_mc_ctrl #(
    .N_DIR(N), .CNT_W(CW), .PRESCALE(1),
    .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1), .PED_EXT_T(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ped_req(ped_req), .flash_mode(flash_mode),
    .red(red), .yellow(yellow), .green(green), .ped_walk(ped_walk),
    .cur_dir(cur_dir)
  );

  always #5 clk = ~clk;

  // frame = {red, yellow, green, ped_walk, cur_dir}
  typedef logic [8:0] frame_t;
  frame_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0=all-red 1=green 2=yellow 3=flash, ticks left in phase
  int         m_phase, m_dir, m_left;
  int         m_dur[4];
  logic [1:0] m_latch, m_fy;
  bit         m_walk;

  function automatic int clamp1(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_dir = 0; m_left = 1;
    m_dur[0] = 4; m_dur[1] = 2; m_dur[2] = 1; m_dur[3] = 3;
    m_latch = '0; m_fy = '0; m_walk = 1'b0;
  endfunction

  function automatic frame_t model_frame();
    logic [1:0] oh, r, y, g, w;
    oh = (m_dir == 1) ? 2'b10 : 2'b01;
    r = 2'b11; y = 2'b00; g = 2'b00;
    case (m_phase)
      1: begin r = ~oh; g = oh; end
      2: begin r = ~oh; y = oh; end
      3: begin r = 2'b00; y = m_fy; end
      default: ;
    endcase
    w = (m_phase == 1 && m_walk) ? oh : 2'b00;
    return {r, y, g, w, m_dir[0]};
  endfunction

  function automatic void model_step(input bit en, input bit we, input int addr,
                                     input int wdata, input logic [1:0] req, input bit fm);
    logic [1:0] clr;
    clr = '0;
    if (fm) begin
      if (m_phase != 3) begin m_phase = 3; m_fy = 2'b11; end
      else if (en) m_fy = ~m_fy;
    end else if (m_phase == 3) begin
      m_phase = 0; m_dir = 0; m_left = clamp1(m_dur[2]);
    end else if (en) begin
      if (m_left > 1) m_left--;
      else begin
        case (m_phase)
          0: begin
            m_walk = m_latch[m_dir];
            m_left = clamp1(m_dur[0] + (m_walk ? m_dur[3] : 0));
            clr[m_dir] = 1'b1;
            m_phase = 1;
          end
          1: begin m_phase = 2; m_left = clamp1(m_dur[1]); end
          default: begin m_phase = 0; m_dir = (m_dir + 1) % N; m_left = clamp1(m_dur[2]); end
        endcase
      end
    end
    m_latch = (m_latch & ~clr) | req;
    if (we) m_dur[addr] = wdata;
  endfunction

  function automatic void check(input string name, input frame_t act, input frame_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b (red,yellow,green,walk,dir)",
               name, $time, act, exp);
    end
  endfunction

  // Monitor: every clock the DUT presents a new frame; compare against the queue
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) check("frame", {red, yellow, green, ped_walk, cur_dir}, exp_q.pop_front());
  end

  task automatic cycle(input bit en, input bit we, input int addr, input int wdata,
                       input logic [1:0] req, input bit fm);
    @(negedge clk);
    reset = 1'b0; enable = en; cfg_we = we; cfg_addr = 2'(addr);
    cfg_wdata = CW'(wdata); ped_req = req; flash_mode = fm;
    model_step(en, we, addr, wdata, req, fm);
    exp_q.push_back(model_frame());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 2'b00, 1'b0);
  endtask

  // Advance until the model is about to show the given phase (dir<0 = any approach)
  task automatic wait_for(input int ph, input int dir, input string name);
    int budget;
    budget = 60;
    while (!(m_phase == ph && (dir < 0 || m_dir == dir)) && budget > 0) begin
      idle(1);
      budget--;
    end
    if (budget == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: phase %0d never reached within budget", name, ph);
    end
  endtask

  initial begin
    bit fm;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", {red, yellow, green, ped_walk, cur_dir}, 9'b11_00_00_00_0);
    model_reset();

    // Basic round-robin sequence
    idle(24);

    // Pedestrian request for approach 1 during approach 0 green
    wait_for(1, 0, "ped_wait");
    cycle(1'b1, 1'b0, 0, 0, 2'b10, 1'b0);
    idle(36);

    // Zero green written mid-green: current green unaffected, next clamped to 1
    wait_for(1, 0, "cfg_wait");
    idle(1);
    cycle(1'b1, 1'b1, 0, 0, 2'b00, 1'b0);
    idle(20);
    cycle(1'b1, 1'b1, 0, 4, 2'b00, 1'b0);
    idle(12);

    // Flash entered mid-yellow, then released
    wait_for(2, -1, "flash_wait");
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 0, 0, 2'b00, 1'b1);
    idle(12);

    // Enable held low mid-green
    wait_for(1, -1, "enable_wait");
    idle(1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0, 0, 2'b00, 1'b0);
    idle(12);

    // Randomized traffic: enable gaps, config writes, ped requests, flash bursts
    fm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!fm && $urandom_range(0, 59) == 0) fm = 1'b1;
      else if (fm && $urandom_range(0, 7) == 0) fm = 1'b0;
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, fm);
    end
    cycle(1'b1, 1'b1, 0, 7, 2'b00, 1'b0);
    cycle(1'b1, 1'b1, 1, 5, 2'b00, 1'b0);
    idle(10);

    // Asynchronous reset mid-yellow; durations must fall back to defaults
    wait_for(2, -1, "reset_wait");
    @(posedge clk);
    #4;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset", {red, yellow, green, ped_walk, cur_dir}, 9'b11_00_00_00_0);
    model_reset();
    repeat (2) @(negedge clk);
    idle(40);

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
